// File: rtl/dm_arbiter_if.sv
// Request/grant/read-data bundle for the two memory requesters plus the
// single-port memory side of the dm_arbiter.
interface dm_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              spi_req;
  logic              spi_we;
  logic [ADDR_W-1:0] spi_addr;
  logic [DATA_W-1:0] spi_wdata;
  logic              spi_gnt;
  logic [DATA_W-1:0] spi_rdata;
  logic              spi_rvalid;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  spi_req, spi_we, spi_addr, spi_wdata,
    input  host_req, host_we, host_addr, host_wdata,
    input  mem_rdata,
    output spi_gnt, spi_rdata, spi_rvalid,
    output host_gnt, host_rdata, host_rvalid,
    output mem_addr, mem_we, mem_wdata
  );

  modport master (
    output spi_req, spi_we, spi_addr, spi_wdata,
    output host_req, host_we, host_addr, host_wdata,
    output mem_rdata,
    input  spi_gnt, spi_rdata, spi_rvalid,
    input  host_gnt, host_rdata, host_rvalid,
    input  mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one registered single-port memory between an
// SPI requester and a host requester; one access per cycle, registered outputs.
module dm_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  dm_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GNT_SPI, GNT_HOST} state_e;
  typedef enum logic {WIN_SPI, WIN_HOST} win_e;

  state_e            state_q, state_d;
  win_e              last_win_q, last_win_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              spi_rvalid_q, spi_rvalid_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic              pick_spi, pick_host;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    pick_spi      = 1'b0;
    pick_host     = 1'b0;
    state_d       = IDLE;
    last_win_d    = last_win_q;
    mem_addr_d    = '0;
    mem_we_d      = 1'b0;
    mem_wdata_d   = '0;
    spi_rvalid_d  = (state_q == GNT_SPI)  && !mem_we_q;
    host_rvalid_d = (state_q == GNT_HOST) && !mem_we_q;

    // The requester in its grant cycle still holds req; only the other side may win.
    case (state_q)
      GNT_SPI:  pick_host = bus.host_req;
      GNT_HOST: pick_spi  = bus.spi_req;
      default: begin
        if (bus.spi_req && bus.host_req) begin
          pick_spi  = (last_win_q == WIN_HOST);
          pick_host = !pick_spi;
        end else begin
          pick_spi  = bus.spi_req;
          pick_host = bus.host_req;
        end
      end
    endcase

    if (pick_spi) begin
      state_d     = GNT_SPI;
      last_win_d  = WIN_SPI;
      mem_addr_d  = bus.spi_addr;
      mem_we_d    = bus.spi_we;
      mem_wdata_d = bus.spi_wdata;
    end else if (pick_host) begin
      state_d     = GNT_HOST;
      last_win_d  = WIN_HOST;
      mem_addr_d  = bus.host_addr;
      mem_we_d    = bus.host_we;
      mem_wdata_d = bus.host_wdata;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_win_q    <= WIN_HOST;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
      spi_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_win_q    <= last_win_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      spi_rvalid_q  <= spi_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

  assign bus.spi_gnt     = (state_q == GNT_SPI);
  assign bus.host_gnt    = (state_q == GNT_HOST);
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.spi_rvalid  = spi_rvalid_q;
  assign bus.host_rvalid = host_rvalid_q;
  // Memory read data arrives the cycle after the address; gate it so rdata is zero otherwise.
  assign bus.spi_rdata   = spi_rvalid_q  ? bus.mem_rdata : '0;
  assign bus.host_rdata  = host_rvalid_q ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: stimulus queues expected grants and read
// responses with their cycle numbers; a negedge monitor pops and compares.
module tb_dm_arbiter;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  typedef struct {
    int                cyc;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } gnt_t;

  typedef struct {
    int                cyc;
    logic [DATA_W-1:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;

  gnt_t spi_gq[$];
  gnt_t host_gq[$];
  rd_t  spi_rq[$];
  rd_t  host_rq[$];

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1] = '{default: '0};

  dm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered single-port memory, read-before-write.
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    failed++;
    $display("FAIL %s: got event/timeout, expected none (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a grant or read data.
  always @(negedge clk) begin
    gnt_t g;
    rd_t  r;
    if (bus.spi_gnt === 1'b1 && bus.host_gnt === 1'b1) fail_now("gnt_overlap");
    if (bus.spi_gnt === 1'b1) begin
      if (spi_gq.size() == 0) fail_now("spi_gnt_unexpected");
      else begin
        g = spi_gq.pop_front();
        check("spi_gnt_cycle", cyc, g.cyc);
        check("spi_mem_we", {31'd0, bus.mem_we}, {31'd0, g.we});
        check("spi_mem_addr", {25'd0, bus.mem_addr}, {25'd0, g.addr});
        if (g.we) check("spi_mem_wdata", {24'd0, bus.mem_wdata}, {24'd0, g.wdata});
      end
    end
    if (bus.host_gnt === 1'b1) begin
      if (host_gq.size() == 0) fail_now("host_gnt_unexpected");
      else begin
        g = host_gq.pop_front();
        check("host_gnt_cycle", cyc, g.cyc);
        check("host_mem_we", {31'd0, bus.mem_we}, {31'd0, g.we});
        check("host_mem_addr", {25'd0, bus.mem_addr}, {25'd0, g.addr});
        if (g.we) check("host_mem_wdata", {24'd0, bus.mem_wdata}, {24'd0, g.wdata});
      end
    end
    if (bus.spi_gnt !== 1'b1 && bus.host_gnt !== 1'b1)
      check("mem_we_idle", {31'd0, bus.mem_we}, 32'd0);
    if (bus.spi_rvalid === 1'b1) begin
      if (spi_rq.size() == 0) fail_now("spi_rvalid_unexpected");
      else begin
        r = spi_rq.pop_front();
        check("spi_rvalid_cycle", cyc, r.cyc);
        check("spi_rdata", {24'd0, bus.spi_rdata}, {24'd0, r.data});
      end
    end
    if (bus.host_rvalid === 1'b1) begin
      if (host_rq.size() == 0) fail_now("host_rvalid_unexpected");
      else begin
        r = host_rq.pop_front();
        check("host_rvalid_cycle", cyc, r.cyc);
        check("host_rdata", {24'd0, bus.host_rdata}, {24'd0, r.data});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit is_host, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = is_host ? (bus.host_gnt === 1'b1) : (bus.spi_gnt === 1'b1);
    end
  endtask

  // Issue one access; lat is the expected grant cycle relative to the cycle req is driven.
  task automatic do_access(input bit is_host, input bit we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input int lat,
                           input logic [DATA_W-1:0] exp_rd, input bit hold);
    gnt_t g;
    rd_t  r;
    bit   seen;
    g.cyc = cyc + lat; g.we = we; g.addr = addr; g.wdata = wdata;
    r.cyc = cyc + lat + 1; r.data = exp_rd;
    if (is_host) begin
      host_gq.push_back(g);
      if (!we) host_rq.push_back(r);
      bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = addr; bus.host_wdata = wdata;
    end else begin
      spi_gq.push_back(g);
      if (!we) spi_rq.push_back(r);
      bus.spi_req = 1'b1; bus.spi_we = we; bus.spi_addr = addr; bus.spi_wdata = wdata;
    end
    wait_gnt(is_host, seen);
    if (!seen) fail_now(is_host ? "host_gnt_timeout" : "spi_gnt_timeout");
    #1;
    // Scramble the payload during the grant cycle; the latched access must not change.
    if (is_host) begin bus.host_addr = ~addr; bus.host_wdata = ~wdata; end
    else begin bus.spi_addr = ~addr; bus.spi_wdata = ~wdata; end
    @(posedge clk);
    #1;
    if (!hold) begin
      if (is_host) bus.host_req = 1'b0;
      else bus.spi_req = 1'b0;
    end
  endtask

  task automatic check_outputs_zero();
    check("rst_spi_gnt", {31'd0, bus.spi_gnt}, 32'd0);
    check("rst_host_gnt", {31'd0, bus.host_gnt}, 32'd0);
    check("rst_spi_rvalid", {31'd0, bus.spi_rvalid}, 32'd0);
    check("rst_host_rvalid", {31'd0, bus.host_rvalid}, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_mem_addr", {25'd0, bus.mem_addr}, 32'd0);
    check("rst_mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);
    check("rst_spi_rdata", {24'd0, bus.spi_rdata}, 32'd0);
    check("rst_host_rdata", {24'd0, bus.host_rdata}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    gnt_t g;
    bit   seen;
    bus.spi_req = 1'b0;  bus.spi_we = 1'b0;  bus.spi_addr = '0;  bus.spi_wdata = '0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;

    // Reset state, then the first request is sampled on the next edge.
    idle(3);
    check_outputs_zero();
    rst_n = 1'b1;

    // SPI write then read-back of 0x05.
    do_access(1'b0, 1'b1, 7'h05, 8'hA5, 1, 8'h00, 1'b0);
    do_access(1'b0, 1'b0, 7'h05, 8'h00, 1, 8'hA5, 1'b0);

    // Tie just after reset: SPI first, host next cycle.
    idle(2);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    fork
      do_access(1'b0, 1'b0, 7'h05, 8'h00, 1, 8'hA5, 1'b0);
      do_access(1'b1, 1'b0, 7'h05, 8'h00, 2, 8'hA5, 1'b0);
    join

    // Host streams reads while SPI streams four writes: strict alternation.
    idle(2);
    fork
      begin
        for (int j = 0; j < 4; j++)
          do_access(1'b0, 1'b1, 7'h30 + 7'(j), 8'hC0 + 8'(j), 1, 8'h00, j < 3);
      end
      begin
        do_access(1'b1, 1'b0, 7'h05, 8'h00, 2, 8'hA5, 1'b1);
        for (int k = 0; k < 4; k++)
          do_access(1'b1, 1'b0, 7'h30 + 7'(k), 8'h00, 1, 8'hC0 + 8'(k), k < 3);
      end
    join

    // Host alone holding req: granted every second cycle, reads only.
    idle(2);
    do_access(1'b1, 1'b0, 7'h30, 8'h00, 1, 8'hC0, 1'b1);
    do_access(1'b1, 1'b0, 7'h31, 8'h00, 1, 8'hC1, 1'b1);
    do_access(1'b1, 1'b0, 7'h05, 8'h00, 1, 8'hA5, 1'b0);

    // Read-before-write ordering with last_win = SPI.
    idle(2);
    do_access(1'b1, 1'b1, 7'h10, 8'h77, 1, 8'h00, 1'b0);
    do_access(1'b0, 1'b1, 7'h20, 8'h11, 1, 8'h00, 1'b0);
    fork
      do_access(1'b1, 1'b0, 7'h10, 8'h00, 1, 8'h77, 1'b0);
      do_access(1'b0, 1'b1, 7'h10, 8'h3C, 2, 8'h00, 1'b0);
    join
    do_access(1'b0, 1'b0, 7'h10, 8'h00, 1, 8'h3C, 1'b0);

    // SPI request withdrawn while the host holds the grant: no SPI access.
    idle(2);
    fork
      do_access(1'b1, 1'b0, 7'h05, 8'h00, 1, 8'hA5, 1'b0);
      begin
        bus.spi_req = 1'b1; bus.spi_we = 1'b1; bus.spi_addr = 7'h7F; bus.spi_wdata = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        #1;
        bus.spi_req = 1'b0;
      end
    join
    idle(3);
    check("drop_no_write", {24'd0, mem[7'h7F]}, 32'd0);

    // Reset during an SPI read grant: no rvalid, outputs cleared, SPI wins next tie.
    g.cyc = cyc + 1; g.we = 1'b0; g.addr = 7'h05; g.wdata = '0;
    spi_gq.push_back(g);
    bus.spi_req = 1'b1; bus.spi_we = 1'b0; bus.spi_addr = 7'h05;
    wait_gnt(1'b0, seen);
    if (!seen) fail_now("rst_gnt_timeout");
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    bus.spi_req = 1'b0;
    check_outputs_zero();
    idle(1);
    rst_n = 1'b1;
    fork
      do_access(1'b0, 1'b0, 7'h30, 8'h00, 1, 8'hC0, 1'b0);
      do_access(1'b1, 1'b0, 7'h31, 8'h00, 2, 8'hC1, 1'b0);
    join

    idle(4);
    check("spi_gq_drained", spi_gq.size(), 32'd0);
    check("host_gq_drained", host_gq.size(), 32'd0);
    check("spi_rq_drained", spi_rq.size(), 32'd0);
    check("host_rq_drained", host_rq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter ADDR_W, 7, memory address width.
REQ-002 Parameter DATA_W, 8, memory data width.
REQ-003 Clocking and reset SHALL be: one clock; reset is synchronous and active-low.
REQ-004 Port clk  input  1  system clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  synchronous active-low reset.
REQ-006 Ports spi_req / host_req  input  1  access request; held high with stable payload until the matching gnt.
REQ-007 Ports spi_we / host_we  input  1  1 = write, 0 = read.
REQ-008 Ports spi_addr / host_addr  input  ADDR_W  access address.
REQ-009 Ports spi_wdata / host_wdata  input  DATA_W  write data.
REQ-010 Ports spi_gnt / host_gnt  output  1  one-cycle grant pulse; the access executes on the memory port in this cycle.
REQ-011 Ports spi_rdata / host_rdata  output  DATA_W  read data; valid only while the matching rvalid is high.
REQ-012 Ports spi_rvalid / host_rvalid  output  1  one-cycle read-data-valid pulse.
REQ-013 Port mem_addr  output  ADDR_W  single-port memory address.
REQ-014 Port mem_we  output  1  memory write enable.
REQ-015 Port mem_wdata  output  DATA_W  memory write data.
REQ-016 Port mem_rdata  input  DATA_W  memory read data, registered: valid one cycle after the address cycle.

Function
REQ-017 Requests SHALL be sampled at rising edge N; the winner's gnt, mem_addr, mem_we and mem_wdata SHALL all be driven from registers during cycle N+1.
REQ-018 For a read granted in cycle N+1, the matching rvalid SHALL pulse in cycle N+2, with rdata equal to mem_rdata captured in that cycle.
REQ-019 mem_we SHALL be high only in a grant cycle of a write and SHALL be 0 in every other cycle.
REQ-020 At most one gnt SHALL be high in any cycle; spi_gnt and host_gnt are mutually exclusive.
REQ-021 When both requests are pending at the sampling edge, the requester not granted most recently SHALL win (round-robin; pointer last_win).
REQ-022 last_win SHALL be set to HOST at reset, so SPI wins the first tie.
REQ-023 When only one request is pending, it SHALL be granted regardless of last_win.
REQ-024 A requester SHALL NOT be re-granted on the edge that ends its own gnt cycle, because its req is still high then; it is eligible again from the following edge.
REQ-025 If the other requester is pending during a grant cycle, it SHALL be granted in the very next cycle (back-to-back alternation, one access per cycle).
REQ-026 A single persistent requester SHALL be granted at most every second cycle.
REQ-027 FSM states SHALL be IDLE, GNT_SPI and GNT_HOST.
REQ-028 FSM transitions SHALL be:
- IDLE to GNT_x on a pending request, per REQ-021 to REQ-023.
- GNT_x to GNT_y when the other requester is pending.
- otherwise GNT_x to IDLE.
REQ-029 A request that is deasserted before its grant SHALL be dropped with no memory access.
REQ-030 Worst-case grant latency for either requester SHALL be 3 cycles from its req assertion.
REQ-031 A read by one requester followed by a write by the other to the same address SHALL return the pre-write data.
REQ-032 Payload SHALL be latched at the sampling edge; changes after grant SHALL have no effect.

Reset
REQ-033 While rst_n is 0 at a rising edge, the block SHALL enter IDLE and set last_win to HOST.
REQ-034 While rst_n is 0 at a rising edge, all gnt, rvalid and mem_we outputs SHALL be 0, and mem_addr, mem_wdata and both rdata outputs SHALL be all zeros.
REQ-035 A reset asserted during a grant or a pending rvalid SHALL cancel it; no rvalid pulse SHALL appear after reset.
REQ-036 After rst_n deasserts, the first request SHALL be sampled at the next rising edge.

Verification
REQ-037 SPI write addr 0x05 data 0xA5, then SPI read 0x05 -> mem_we pulses once with mem_addr 0x05 and mem_wdata 0xA5; the read returns spi_rdata 0xA5 with spi_rvalid two cycles after sampling.
REQ-038 Both requesters assert a read on the same edge just after reset -> spi_gnt in cycle N+1 and host_gnt in N+2; rvalids follow in N+2 and N+3; gnts are never overlapping.
REQ-039 Host holds req continuously while SPI issues 4 accesses -> gnts alternate SPI/HOST every cycle; neither requester waits more than 3 cycles.
REQ-040 Host alone holds req for 6 cycles -> host_gnt on alternate cycles only; mem_we is 0 for reads.
REQ-041 Host read 0x10 and SPI write 0x10 (new value 0x3C) pending together with last_win = SPI -> host reads the old value, then memory holds 0x3C.
REQ-042 rst_n driven low in a read grant cycle -> no rvalid next cycle; all outputs 0; the next tie goes to SPI.
